bsg_link_sdr_credit_endpoint: RTL

Single-clock, full-duplex, parametrised link endpoint with a transmit path and a receive path.
- Transmit: serialises `width_p`-bit core words into beats over `num_channels_p` lanes of `channel_width_p` bits, metered by a credit counter refilled by tokens.
- Receive: deserialises incoming beats into a `fifo_els_p`-word buffer and returns decimated credit tokens.

It is the next generation of the DDR upstream/downstream pair: arbitrary width, lane count, buffer depth and credit decimation, plus a sticky overflow error. It targets on-chip or same-clock chiplet links.

---
 rtl/bsg_link_sdr_credit_endpoint.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bsg_link_sdr_credit_endpoint.sv
// Single-clock full-duplex SDR link endpoint.
// Transmit: credit-metered serialiser from core words to link beats.
// Receive: deserialiser into a circular buffer with decimated credit-token return.
module bsg_link_sdr_credit_endpoint #(
    parameter int width_p                = 64,
    parameter int channel_width_p        = 16,
    parameter int num_channels_p         = 1,
    parameter int fifo_els_p             = 8,
    parameter int lg_credit_decimation_p = 2
) (
    input  logic                                      core_clk_i,
    input  logic                                      core_link_reset_n_i,
    input  logic [width_p-1:0]                        core_data_i,
    input  logic                                      core_valid_i,
    output logic                                      core_ready_o,
    output logic [channel_width_p*num_channels_p-1:0] link_data_o,
    output logic                                      link_valid_o,
    input  logic                                      link_token_i,
    input  logic [channel_width_p*num_channels_p-1:0] link_data_i,
    input  logic                                      link_valid_i,
    output logic                                      link_token_o,
    output logic [width_p-1:0]                        core_data_o,
    output logic                                      core_valid_o,
    input  logic                                      core_yumi_i,
    output logic                                      error_o
);

    localparam int link_w_lp   = channel_width_p * num_channels_p;
    localparam int beats_lp    = width_p / link_w_lp;
    localparam int beat_w_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int credit_w_lp = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int dec_w_lp    = (lg_credit_decimation_p > 0) ? lg_credit_decimation_p : 1;

    localparam logic [beat_w_lp-1:0]   last_beat_lp     = beat_w_lp'(beats_lp - 1);
    localparam logic [credit_w_lp-1:0] max_credits_lp   = credit_w_lp'(fifo_els_p);
    localparam logic [credit_w_lp:0]   token_credits_lp = (credit_w_lp + 1)'(2 ** lg_credit_decimation_p);
    localparam logic [ptr_w_lp-1:0]    last_ptr_lp      = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [dec_w_lp-1:0]    last_dec_lp      = dec_w_lp'(2 ** lg_credit_decimation_p - 1);

    typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

    tx_state_e              tx_state_q, tx_state_n;
    logic [beat_w_lp-1:0]   tx_beat_q, tx_beat_n;
    logic [width_p-1:0]     tx_word_q, tx_word_n;
    logic [link_w_lp-1:0]   link_data_n;
    logic                   link_valid_n;
    logic                   tx_last, tx_accept;
    logic [credit_w_lp-1:0] credits_q, credits_n;
    logic [credit_w_lp:0]   credit_sum;

    logic [beat_w_lp-1:0]   rx_beat_q;
    logic [width_p-1:0]     rx_asm_q, rx_word;
    logic                   rx_enq, rx_full, rx_deq, rx_enq_fire;
    logic [width_p-1:0]     rx_mem [fifo_els_p];
    logic [ptr_w_lp-1:0]    rx_wr_ptr_q, rx_rd_ptr_q;
    logic [credit_w_lp-1:0] rx_count_q;
    logic [dec_w_lp-1:0]    dec_q;

    // Transmit next-state: link_data_o/link_valid_o always show the beat selected by tx_beat_q.
    always_comb begin
        tx_state_n   = tx_state_q;
        tx_beat_n    = tx_beat_q;
        tx_word_n    = tx_word_q;
        link_data_n  = link_data_o;
        link_valid_n = link_valid_o;
        tx_last      = (tx_state_q == TX_SEND) && (tx_beat_q == last_beat_lp);
        core_ready_o = ((tx_state_q == TX_IDLE) || tx_last) && (credits_q != '0);
        tx_accept    = core_valid_i && core_ready_o;
        if (tx_accept) begin
            tx_state_n   = TX_SEND;
            tx_beat_n    = '0;
            tx_word_n    = core_data_i;
            link_data_n  = core_data_i[0 +: link_w_lp];
            link_valid_n = 1'b1;
        end else if (tx_state_q == TX_SEND) begin
            if (tx_last) begin
                tx_state_n   = TX_IDLE;
                link_valid_n = 1'b0;
            end else begin
                tx_beat_n   = tx_beat_q + 1'b1;
                link_data_n = tx_word_q[int'(tx_beat_n) * link_w_lp +: link_w_lp];
            end
        end
    end

    // Credit update: net of one accept and one token, saturating at the buffer depth.
    always_comb begin
        credit_sum = {1'b0, credits_q} - (credit_w_lp + 1)'(tx_accept)
                   + (link_token_i ? token_credits_lp : '0);
        credits_n  = (credit_sum > {1'b0, max_credits_lp}) ? max_credits_lp
                                                           : credit_sum[credit_w_lp-1:0];
    end

    // Transmit state, beat output and credit registers.
    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            tx_state_q   <= TX_IDLE;
            tx_beat_q    <= '0;
            tx_word_q    <= '0;
            link_data_o  <= '0;
            link_valid_o <= 1'b0;
            credits_q    <= max_credits_lp;
        end else begin
            tx_state_q   <= tx_state_n;
            tx_beat_q    <= tx_beat_n;
            tx_word_q    <= tx_word_n;
            link_data_o  <= link_data_n;
            link_valid_o <= link_valid_n;
            credits_q    <= credits_n;
        end
    end

    // Flag a token that would push credits past the buffer depth.
    always_ff @(posedge core_clk_i) begin
        if (core_link_reset_n_i) assert (credit_sum <= {1'b0, max_credits_lp});
    end

    // Receive assembly and buffer control; the word enqueued includes the current beat.
    always_comb begin
        rx_word = rx_asm_q;
        rx_word[int'(rx_beat_q) * link_w_lp +: link_w_lp] = link_data_i;
        rx_enq      = link_valid_i && (rx_beat_q == last_beat_lp);
        rx_full     = (rx_count_q == max_credits_lp);
        rx_deq      = core_yumi_i && core_valid_o;
        rx_enq_fire = rx_enq && (!rx_full || rx_deq);
    end

    // Receive beat counter, assembly register, buffer pointers, overflow flag.
    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            rx_beat_q   <= '0;
            rx_asm_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            error_o     <= 1'b0;
        end else begin
            if (link_valid_i) begin
                rx_asm_q  <= rx_word;
                rx_beat_q <= (rx_beat_q == last_beat_lp) ? '0 : rx_beat_q + 1'b1;
            end
            if (rx_enq_fire)
                rx_wr_ptr_q <= (rx_wr_ptr_q == last_ptr_lp) ? '0 : rx_wr_ptr_q + 1'b1;
            if (rx_deq)
                rx_rd_ptr_q <= (rx_rd_ptr_q == last_ptr_lp) ? '0 : rx_rd_ptr_q + 1'b1;
            rx_count_q <= rx_count_q + credit_w_lp'(rx_enq_fire) - credit_w_lp'(rx_deq);
            if (rx_enq && rx_full && !rx_deq)
                error_o <= 1'b1;
        end
    end

    // Buffer storage; contents need no reset because the count governs validity.
    always_ff @(posedge core_clk_i) begin
        if (rx_enq_fire) rx_mem[rx_wr_ptr_q] <= rx_word;
    end

    assign core_data_o  = rx_mem[rx_rd_ptr_q];
    assign core_valid_o = (rx_count_q != '0);

    // Token return: one pulse per 2^lg_credit_decimation_p consumed words.
    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            dec_q        <= '0;
            link_token_o <= 1'b0;
        end else begin
            link_token_o <= rx_deq && (dec_q == last_dec_lp);
            if (rx_deq) dec_q <= (dec_q == last_dec_lp) ? '0 : dec_q + 1'b1;
        end
    end

endmodule
